load_store_unit: RTL and testbench
==================================

# load_store_unit

Initiator side of the data-memory port. Accepts one load or store at a time from the core's memory stage and drives the word-addressed, byte-masked memory request interface. For stores it builds the byte mask and lane-shifts the write data. For loads it waits for the memory response, then extracts and sign- or zero-extends the addressed byte, halfword or word. Misaligned accesses, illegal encodings and missing responses are reported with the completion pulse.

## Interface
- TIMEOUT, 15: maximum number of WAIT cycles without `mem_valid` before the load is aborted (1..255).
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- lsu_start  in  1  one-cycle request pulse; sampled only in IDLE
- lsu_is_store  in  1  1 = store, 0 = load
- lsu_funct3  in  3  RV32I width code; loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW
- lsu_addr  in  32  byte address
- lsu_wdata  in  32  store data, right-aligned
- lsu_busy  out  1  high in every state except IDLE
- lsu_done  out  1  one-cycle completion pulse
- lsu_rdata  out  32  load result; valid while `lsu_done`, held until the next load completes
- lsu_error  out  2  status, qualified by `lsu_done`; 00 ok, 01 misaligned, 10 illegal funct3, 11 timeout
- mem_request  out  1  memory access strobe
- mem_we_re  out  1  1 = write, 0 = read
- mem_address  out  12  word index, equal to `lsu_addr[13:2]`
- mem_mask  out  4  byte-lane write enables
- mem_data_in  out  32  lane-aligned write data
- mem_data_out  in  32  read data from memory
- mem_valid  in  1  read response valid

## Operation
- **Capture.** In IDLE, with `lsu_start` high, register is_store, funct3, addr and wdata. Ignore `lsu_start` in all other states.
- **Decode on capture.**
  - Illegal funct3 gives error 10. Illegal codes are: load 011, 110, 111; store 011 and 1xx.
  - Otherwise misalignment gives error 01. Halfword is misaligned when addr[0]=1. Word is misaligned when addr[1:0]≠00.
  - Any error goes directly to DONE, and no memory request is issued.
- **States.** IDLE → ISSUE → (store) DONE, or (load) WAIT → DONE → IDLE.
  - **ISSUE**
    - `mem_request`=1 for exactly one cycle; `mem_we_re` = is_store.
    - Store mask:
      - SB: 0001 << addr[1:0]
      - SH: 0011 << addr[1:0]
      - SW: 1111
    - Store data:
      - SB: byte replicated into all four lanes.
      - SH: halfword replicated into both halves.
      - SW: as is.
    - Loads drive `mem_mask`=0000.
  - **WAIT**
    - The first cycle with `mem_valid`=1 captures `mem_data_out` and moves to DONE.
    - An 8-bit counter counts WAIT cycles. After TIMEOUT cycles without `mem_valid`, move to DONE with error 11; `lsu_rdata` is unchanged.
  - **DONE**: `lsu_done`=1 for one cycle, then return to IDLE.
- **Load extract.**
  - Select the byte at addr[1:0], or the halfword at addr[1].
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word through.
- **Address range.** Address bits [31:14] are ignored; there is no range check.

## Timing
- All outputs are registered or decoded from registered state only. There is no combinational path from `lsu_*` or `mem_*` inputs to outputs.
- **Reset** forces state IDLE, counter 0, and these outputs to 0: `lsu_busy`, `lsu_done`, `lsu_rdata`, `lsu_error`, `mem_request`, `mem_we_re`, `mem_address`, `mem_mask`, `mem_data_in`.
- **Reset mid-operation** aborts immediately. No `lsu_done` is produced, and `mem_request` is low from the next cycle.
- **Cycle counts**, with start sampled at edge 0:
  - Store: ISSUE in cycle 1, `lsu_done` in cycle 2.
  - Load with `mem_valid` in the first WAIT cycle: ISSUE in cycle 1, WAIT in cycle 2, `lsu_done` in cycle 3.
  - Error: `lsu_done` in cycle 1.
  - Timeout: `lsu_done` in cycle 2+TIMEOUT.
- **Response window.** The memory returns read data one edge after the request, so `mem_valid` is honoured only in WAIT. `mem_valid` seen in any other state, including a stale level left high from an earlier read, is ignored.
- **Back-to-back.** A `lsu_start` in the DONE cycle is dropped. The next access can be accepted the cycle after DONE.
- **Write timing.** Store data and mask are stable only during ISSUE. The memory writes at the ISSUE/next edge.

## Test plan
- **SW**: addr 0x0000_0104, wdata 0xDEADBEEF → ISSUE shows address 0x041, mask 1111, data 0xDEADBEEF, we_re 1; `lsu_done` in cycle 2, error 00.
- **SB then LB/LBU**:
  - SB at addr 0x0000_0107 with wdata 0x0000_0080 → mask 1000, data 0x80808080.
  - LB from 0x107 → rdata 0xFFFF_FF80.
  - LBU from 0x107 → rdata 0x0000_0080; done 3 cycles after start.
- **LH/LHU at addr 0x102**, memory word 0x8001_7FFF → LH gives 0xFFFF_8001, LHU gives 0x0000_8001.
- **Errors**:
  - LW at 0x0000_0102 → error 01, done in cycle 1, `mem_request` never high.
  - Store funct3 100 → error 10.
- **Timeout**: TIMEOUT=4, load with `mem_valid` held 0 → `lsu_done` in cycle 6, error 11, rdata unchanged.
- **Reset and ignored inputs**:
  - `rst` asserted during WAIT → next cycle busy 0, no done, all outputs 0.
  - `lsu_start` asserted while busy is ignored, with no second request.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Bundle of the core-side request/response signals and the word-addressed,
// byte-masked data-memory port used by the load/store unit.
interface load_store_unit_if;
  logic        lsu_start;
  logic        lsu_is_store;
  logic [2:0]  lsu_funct3;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic        lsu_busy;
  logic        lsu_done;
  logic [31:0] lsu_rdata;
  logic [1:0]  lsu_error;
  logic        mem_request;
  logic        mem_we_re;
  logic [11:0] mem_address;
  logic [3:0]  mem_mask;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;
  logic        mem_valid;

  // View of the load/store unit itself
  modport slave (
    input  lsu_start, lsu_is_store, lsu_funct3, lsu_addr, lsu_wdata,
    input  mem_data_out, mem_valid,
    output lsu_busy, lsu_done, lsu_rdata, lsu_error,
    output mem_request, mem_we_re, mem_address, mem_mask, mem_data_in
  );

  // View of the surrounding core and memory
  modport master (
    output lsu_start, lsu_is_store, lsu_funct3, lsu_addr, lsu_wdata,
    output mem_data_out, mem_valid,
    input  lsu_busy, lsu_done, lsu_rdata, lsu_error,
    input  mem_request, mem_we_re, mem_address, mem_mask, mem_data_in
  );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store initiator: decodes one access, drives one
// memory request, and returns the extended load result with a status code.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 15
) (
  input logic               clk,
  input logic               rst,
  load_store_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        is_store_q, is_store_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [13:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;

  // Illegal width codes take priority over misalignment.
  function automatic logic [1:0] decode_error(input logic st, input logic [2:0] f3,
                                              input logic [1:0] off);
    logic illegal;
    logic misal;
    if (st) begin
      illegal = (f3 == 3'b011) | f3[2];
    end else begin
      illegal = (f3 == 3'b011) | (f3 == 3'b110) | (f3 == 3'b111);
    end
    case (f3[1:0])
      2'b01:   misal = off[0];
      2'b10:   misal = (off != 2'b00);
      default: misal = 1'b0;
    endcase
    if (illegal) begin
      return 2'b10;
    end else if (misal) begin
      return 2'b01;
    end else begin
      return 2'b00;
    end
  endfunction

  function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
    case (f3[1:0])
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'h00_0000, b};
      3'b101:  return {16'h0000, h};
      default: return word;
    endcase
  endfunction

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      is_store_q <= 1'b0;
      funct3_q   <= 3'b000;
      addr_q     <= 14'h0000;
      wdata_q    <= 32'h0000_0000;
      rdata_q    <= 32'h0000_0000;
      err_q      <= 2'b00;
      cnt_q      <= 8'h00;
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
      funct3_q   <= funct3_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  // Next-state and capture logic
  always_comb begin
    state_d    = state_q;
    is_store_d = is_store_q;
    funct3_d   = funct3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.lsu_start) begin
          is_store_d = bus.lsu_is_store;
          funct3_d   = bus.lsu_funct3;
          addr_d     = bus.lsu_addr[13:0];
          wdata_d    = bus.lsu_wdata;
          err_d      = decode_error(bus.lsu_is_store, bus.lsu_funct3, bus.lsu_addr[1:0]);
          state_d    = (err_d != 2'b00) ? ST_DONE : ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = 8'h00;
        state_d = is_store_q ? ST_DONE : ST_WAIT;
      end
      ST_WAIT: begin
        // A response in the final allowed cycle still wins over the timeout.
        if (bus.mem_valid) begin
          rdata_d = load_extract(funct3_q, addr_q[1:0], bus.mem_data_out);
          state_d = ST_DONE;
        end else if (cnt_q == TO_LAST) begin
          err_d   = 2'b11;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 8'h01;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from registered state only
  always_comb begin
    bus.lsu_busy    = (state_q != ST_IDLE);
    bus.lsu_done    = (state_q == ST_DONE);
    bus.lsu_rdata   = rdata_q;
    bus.lsu_error   = err_q;
    bus.mem_address = addr_q[13:2];
    bus.mem_request = 1'b0;
    bus.mem_we_re   = 1'b0;
    bus.mem_mask    = 4'b0000;
    bus.mem_data_in = 32'h0000_0000;
    if (state_q == ST_ISSUE) begin
      bus.mem_request = 1'b1;
      bus.mem_we_re   = is_store_q;
      if (is_store_q) begin
        bus.mem_mask    = store_mask(funct3_q, addr_q[1:0]);
        bus.mem_data_in = store_data(funct3_q, wdata_q);
      end else begin
        bus.mem_mask    = 4'b0000;
        bus.mem_data_in = 32'h0000_0000;
      end
    end else begin
      bus.mem_request = 1'b0;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed, table-driven bench for load_store_unit with a short response timeout.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  load_store_unit_if bus();

  load_store_unit #(.TIMEOUT(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] word;
    int          vcyc;
    int          exp_done;
    int          exp_req;
    logic [11:0] exp_maddr;
    logic [3:0]  exp_mask;
    logic [31:0] exp_mdata;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_err;
  } vec_t;

  vec_t        vecs[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] last_rdata = 32'h0000_0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, " busy"},     32'(bus.lsu_busy),    32'h0);
    check({tag, " done"},     32'(bus.lsu_done),    32'h0);
    check({tag, " rdata"},    bus.lsu_rdata,        32'h0);
    check({tag, " error"},    32'(bus.lsu_error),   32'h0);
    check({tag, " request"},  32'(bus.mem_request), 32'h0);
    check({tag, " we_re"},    32'(bus.mem_we_re),   32'h0);
    check({tag, " address"},  32'(bus.mem_address), 32'h0);
    check({tag, " mask"},     32'(bus.mem_mask),    32'h0);
    check({tag, " data_in"},  bus.mem_data_in,      32'h0);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int done_cyc = 0, req_cyc = 0, n_done = 0, n_req = 0;
    logic [31:0] got_rdata = 32'h0, got_mdata = 32'h0;
    logic [1:0]  got_err = 2'b00;
    logic [11:0] got_maddr = 12'h0;
    logic [3:0]  got_mask = 4'h0;
    logic        got_we = 1'b0;
    string       t;
    t = $sformatf("vec%0d", idx);
    @(negedge clk);
    bus.lsu_start    = 1'b1;
    bus.lsu_is_store = v.st;
    bus.lsu_funct3   = v.f3;
    bus.lsu_addr     = v.addr;
    bus.lsu_wdata    = v.wdata;
    bus.mem_data_out = v.word;
    bus.mem_valid    = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) bus.lsu_start = 1'b0;
      if (bus.mem_request) begin
        n_req++;
        if (req_cyc == 0) req_cyc = c;
        got_maddr = bus.mem_address;
        got_mask  = bus.mem_mask;
        got_mdata = bus.mem_data_in;
        got_we    = bus.mem_we_re;
      end
      if (bus.lsu_done) begin
        n_done++;
        if (done_cyc == 0) begin
          done_cyc  = c;
          got_rdata = bus.lsu_rdata;
          got_err   = bus.lsu_error;
        end
      end
      bus.mem_valid = (c == v.vcyc);
    end
    bus.mem_valid = 1'b0;
    if (!v.st && v.exp_err == 2'b00) last_rdata = v.exp_rdata;
    check({t, " done_cycle"}, 32'(done_cyc), 32'(v.exp_done));
    check({t, " done_count"}, 32'(n_done), 32'd1);
    check({t, " req_count"},  32'(n_req), 32'(v.exp_req));
    check({t, " error"},      32'(got_err), 32'(v.exp_err));
    check({t, " rdata"},      got_rdata, last_rdata);
    if (v.exp_req != 0) begin
      check({t, " req_cycle"}, 32'(req_cyc), 32'd1);
      check({t, " address"},   32'(got_maddr), 32'(v.exp_maddr));
      check({t, " mask"},      32'(got_mask), 32'(v.exp_mask));
      check({t, " we_re"},     32'(got_we), 32'(v.st));
      if (v.st) check({t, " data_in"}, got_mdata, v.exp_mdata);
    end
  endtask

  initial begin
    int n_req, n_done;
    bus.lsu_start = 1'b0; bus.lsu_is_store = 1'b0; bus.lsu_funct3 = 3'b000;
    bus.lsu_addr = 32'h0; bus.lsu_wdata = 32'h0;
    bus.mem_data_out = 32'h0; bus.mem_valid = 1'b0;

    //           st    f3      addr          wdata         word      vcyc done req maddr   mask    mdata         rdata         err
    vecs.push_back('{1'b1, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0,          0, 2, 1, 12'h041, 4'b1111, 32'hDEAD_BEEF, 32'h0,         2'b00});
    vecs.push_back('{1'b1, 3'b000, 32'h0000_0107, 32'h0000_0080, 32'h0,          0, 2, 1, 12'h041, 4'b1000, 32'h8080_8080, 32'h0,         2'b00});
    vecs.push_back('{1'b0, 3'b000, 32'h0000_0107, 32'h0,         32'h8080_8080,  2, 3, 1, 12'h041, 4'b0000, 32'h0,         32'hFFFF_FF80, 2'b00});
    vecs.push_back('{1'b0, 3'b100, 32'h0000_0107, 32'h0,         32'h8080_8080,  2, 3, 1, 12'h041, 4'b0000, 32'h0,         32'h0000_0080, 2'b00});
    vecs.push_back('{1'b0, 3'b001, 32'h0000_0102, 32'h0,         32'h8001_7FFF,  2, 3, 1, 12'h040, 4'b0000, 32'h0,         32'hFFFF_8001, 2'b00});
    vecs.push_back('{1'b0, 3'b101, 32'h0000_0102, 32'h0,         32'h8001_7FFF,  2, 3, 1, 12'h040, 4'b0000, 32'h0,         32'h0000_8001, 2'b00});
    vecs.push_back('{1'b0, 3'b010, 32'h0000_0102, 32'h0,         32'h0,          0, 1, 0, 12'h040, 4'b0000, 32'h0,         32'h0,         2'b01});
    vecs.push_back('{1'b1, 3'b100, 32'h0000_0100, 32'h1,         32'h0,          0, 1, 0, 12'h040, 4'b0000, 32'h0,         32'h0,         2'b10});
    vecs.push_back('{1'b1, 3'b001, 32'hFFFF_FFFE, 32'h1234_ABCD, 32'h0,          0, 2, 1, 12'hFFF, 4'b1100, 32'hABCD_ABCD, 32'h0,         2'b00});
    vecs.push_back('{1'b1, 3'b000, 32'h0000_0105, 32'hFFFF_FF5A, 32'h0,          0, 2, 1, 12'h041, 4'b0010, 32'h5A5A_5A5A, 32'h0,         2'b00});
    vecs.push_back('{1'b0, 3'b000, 32'h0000_0101, 32'h0,         32'h1234_F678,  2, 3, 1, 12'h040, 4'b0000, 32'h0,         32'hFFFF_FFF6, 2'b00});
    vecs.push_back('{1'b0, 3'b001, 32'h0000_0100, 32'h0,         32'h8001_7FFF,  2, 3, 1, 12'h040, 4'b0000, 32'h0,         32'h0000_7FFF, 2'b00});
    vecs.push_back('{1'b0, 3'b001, 32'h0000_0101, 32'h0,         32'h0,          0, 1, 0, 12'h040, 4'b0000, 32'h0,         32'h0,         2'b01});
    vecs.push_back('{1'b1, 3'b001, 32'h0000_0101, 32'h0,         32'h0,          0, 1, 0, 12'h040, 4'b0000, 32'h0,         32'h0,         2'b01});
    vecs.push_back('{1'b0, 3'b011, 32'h0000_0103, 32'h0,         32'h0,          0, 1, 0, 12'h040, 4'b0000, 32'h0,         32'h0,         2'b10});
    vecs.push_back('{1'b0, 3'b110, 32'h0000_0100, 32'h0,         32'h0,          0, 1, 0, 12'h040, 4'b0000, 32'h0,         32'h0,         2'b10});
    vecs.push_back('{1'b0, 3'b111, 32'h0000_0100, 32'h0,         32'h0,          0, 1, 0, 12'h040, 4'b0000, 32'h0,         32'h0,         2'b10});
    vecs.push_back('{1'b1, 3'b011, 32'h0000_0100, 32'h0,         32'h0,          0, 1, 0, 12'h040, 4'b0000, 32'h0,         32'h0,         2'b10});
    vecs.push_back('{1'b0, 3'b010, 32'h0000_0108, 32'h0,         32'hCAFE_F00D,  2, 3, 1, 12'h042, 4'b0000, 32'h0,         32'hCAFE_F00D, 2'b00});
    vecs.push_back('{1'b0, 3'b010, 32'h0000_010C, 32'h0,         32'h1111_2222,  0, 6, 1, 12'h043, 4'b0000, 32'h0,         32'h0,         2'b11});
    vecs.push_back('{1'b0, 3'b010, 32'h0000_0110, 32'h0,         32'h3333_4444,  1, 6, 1, 12'h044, 4'b0000, 32'h0,         32'h0,         2'b11});
    vecs.push_back('{1'b0, 3'b101, 32'h0000_0112, 32'h0,         32'hBEEF_1234,  4, 5, 1, 12'h044, 4'b0000, 32'h0,         32'h0000_BEEF, 2'b00});
    vecs.push_back('{1'b0, 3'b100, 32'h0000_0113, 32'h0,         32'hA500_0000,  5, 6, 1, 12'h044, 4'b0000, 32'h0,         32'h0000_00A5, 2'b00});

    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b0;

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Reset while a load sits in WAIT with no response coming
    @(negedge clk);
    bus.lsu_start = 1'b1; bus.lsu_is_store = 1'b0; bus.lsu_funct3 = 3'b010;
    bus.lsu_addr = 32'h0000_0108; bus.mem_valid = 1'b0;
    @(negedge clk); bus.lsu_start = 1'b0;
    @(negedge clk);
    check("midreset in_wait busy", 32'(bus.lsu_busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_zero_outputs("midreset");
    rst = 1'b0;
    n_req = 0; n_done = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.mem_request) n_req++;
      if (bus.lsu_done) n_done++;
    end
    check("midreset late_req", 32'(n_req), 32'd0);
    check("midreset late_done", 32'(n_done), 32'd0);
    last_rdata = 32'h0000_0000;

    // lsu_start held through ISSUE and DONE must not launch a second access
    @(negedge clk);
    bus.lsu_start = 1'b1; bus.lsu_is_store = 1'b1; bus.lsu_funct3 = 3'b010;
    bus.lsu_addr = 32'h0000_0200; bus.lsu_wdata = 32'h0000_0001;
    n_req = 0; n_done = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 3) bus.lsu_start = 1'b0;
      if (bus.mem_request) n_req++;
      if (bus.lsu_done) n_done++;
    end
    check("held_start req_count", 32'(n_req), 32'd1);
    check("held_start done_count", 32'(n_done), 32'd1);

    // Recovery: an ordinary load after the reset and the ignored starts
    run_vec(100, vecs[18]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
